// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_unit_if : core request/response and data-memory port bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [31:0]           req_addr_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  mem_wr_o;
  logic [ADDR_WIDTH-1:0] mem_waddr_o;
  logic [ADDR_WIDTH-1:0] mem_raddr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
           req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_wr_o, mem_waddr_o, mem_raddr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
           req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_wr_o, mem_waddr_o, mem_raddr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_unit : byte/half/word load-store unit with read-modify-write
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_access_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]            r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic                  r_err;
  logic [1:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_req_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merge;
  logic                  w_unused_addr;

  assign w_unused_addr = ^bus.req_addr_i[31:ADDR_WIDTH+2];

  assign w_req_err = (bus.req_size_i == 2'b11) ||
                     (bus.req_size_i == SZ_HALF && bus.req_addr_i[0]) ||
                     (bus.req_size_i == SZ_WORD && bus.req_addr_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_off      <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_we       <= bus.req_we_i;
            r_size     <= bus.req_size_i;
            r_unsigned <= bus.req_unsigned_i;
            r_err      <= w_req_err;
            r_off      <= bus.req_addr_i[1:0];
            r_addr     <= bus.req_addr_i[ADDR_WIDTH+1:2];
            r_wdata    <= bus.req_wdata_i;
            if (w_req_err)
              r_state <= S_RESP;
            else if (bus.req_we_i && bus.req_size_i == SZ_WORD)
              r_state <= S_WR;
            else
              r_state <= S_RD;
          end
        end
        // RD serves both loads and the read half of a sub-word store
        S_RD: begin
          r_rdata <= bus.mem_rdata_i;
          r_state <= r_we ? S_WR : S_RESP;
        end
        S_WR:    r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_byte = r_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      2'd3:    w_byte = r_rdata[31:24];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];
  end

  always_comb begin
    w_load = r_rdata;
    case (r_size)
      SZ_BYTE: w_load = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                   : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      SZ_HALF: w_load = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                   : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    w_merge = r_rdata;
    if (r_size == SZ_BYTE) begin
      case (r_off)
        2'd0:    w_merge[7:0]   = r_wdata[7:0];
        2'd1:    w_merge[15:8]  = r_wdata[7:0];
        2'd2:    w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end else if (r_off[1]) begin
      w_merge[31:16] = r_wdata[15:0];
    end else begin
      w_merge[15:0] = r_wdata[15:0];
    end
  end

  // Ready is gated by rst_ni so it stays low for the whole reset interval
  assign bus.req_ready_o = rst_ni && (r_state == S_IDLE);
  assign bus.rsp_valid_o = (r_state == S_RESP);
  assign bus.rsp_err_o   = (r_state == S_RESP) && r_err;
  assign bus.rsp_rdata_o = (r_state == S_RESP && !r_we && !r_err) ? w_load : '0;

  assign bus.mem_wr_o    = (r_state == S_WR);
  assign bus.mem_waddr_o = r_addr;
  assign bus.mem_raddr_o = r_addr;
  assign bus.mem_wdata_o = (r_state != S_WR) ? '0 :
                           (r_size == SZ_WORD) ? r_wdata : w_merge;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access_unit : directed vector bench with a behavioural data memory
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  mem_access_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [31:0] mem [0:1023];

  assign bus.mem_rdata_i = mem[bus.mem_raddr_o];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (i == 4) ? 32'h11223344 : (i == 5) ? 32'h8899AABB : 32'h0;
    end else if (bus.mem_wr_o) begin
      mem[bus.mem_waddr_o] <= bus.mem_wdata_o;
    end
  end

  int          wr_count = 0;
  logic [31:0] last_wd = 32'h0;
  int          idle_viol = 0;

  always @(negedge clk) begin
    if (bus.mem_wr_o) begin
      wr_count <= wr_count + 1;
      last_wd  <= bus.mem_wdata_o;
    end
    if (rst_n && !bus.mem_wr_o && bus.mem_wdata_o != 32'h0)
      idle_viol <= idle_viol + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwr;
    logic [31:0] mwdata;
    int          idx;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [17];

  task automatic apply(input vec_t v, input int n);
    int          lat;
    bit          got;
    logic        e;
    logic [31:0] d;
    int          w0;
    @(negedge clk);
    check($sformatf("v%0d_ready", n), {31'b0, bus.req_ready_o}, 32'd1);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = v.we;
    bus.req_addr_i     = v.addr;
    bus.req_size_i     = v.size;
    bus.req_unsigned_i = v.uns;
    bus.req_wdata_i    = v.wdata;
    w0 = wr_count;
    @(posedge clk);
    #1;
    // Junk on the non-valid inputs must not disturb the operation in flight
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = ~v.we;
    bus.req_addr_i     = 32'hFFFF_FFFF;
    bus.req_size_i     = 2'b11;
    bus.req_unsigned_i = ~v.uns;
    bus.req_wdata_i    = 32'hDEAD_BEEF;
    lat = 0;
    got = 1'b0;
    e   = 1'b0;
    d   = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      if (!got) begin
        @(negedge clk);
        if (bus.rsp_valid_o) begin
          got = 1'b1;
          lat = c;
          e   = bus.rsp_err_o;
          d   = bus.rsp_rdata_o;
        end
      end
    end
    check($sformatf("v%0d_latency", n), lat, v.lat);
    check($sformatf("v%0d_err", n), {31'b0, e}, {31'b0, v.err});
    check($sformatf("v%0d_rdata", n), d, v.rdata);
    @(negedge clk);
    check($sformatf("v%0d_rsp_one_cycle", n), {31'b0, bus.rsp_valid_o}, 32'd0);
    check($sformatf("v%0d_nwrites", n), wr_count - w0, v.nwr);
    if (v.nwr > 0)
      check($sformatf("v%0d_mem_wdata", n), last_wd, v.mwdata);
    check($sformatf("v%0d_mem_word", n), mem[v.idx], v.word);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          rsp;
    int          bad;
    int          acc_at [10];
    bit          seen;
    int          w0;

    //            we    addr           sz     uns   wdata          err   rdata          lat nwr mwdata         idx word
    vecs[0]  = '{1'b0, 32'h0000_0016, 2'b00, 1'b0, 32'h0,         1'b0, 32'hFFFFFF99, 2, 0, 32'h0,         5, 32'h8899AABB};
    vecs[1]  = '{1'b0, 32'h0000_0014, 2'b01, 1'b1, 32'h0,         1'b0, 32'h0000AABB, 2, 0, 32'h0,         5, 32'h8899AABB};
    vecs[2]  = '{1'b0, 32'h0000_0014, 2'b10, 1'b0, 32'h0,         1'b0, 32'h8899AABB, 2, 0, 32'h0,         5, 32'h8899AABB};
    vecs[3]  = '{1'b0, 32'h0000_0017, 2'b00, 1'b1, 32'h0,         1'b0, 32'h00000088, 2, 0, 32'h0,         5, 32'h8899AABB};
    vecs[4]  = '{1'b0, 32'h0000_0016, 2'b01, 1'b0, 32'h0,         1'b0, 32'hFFFF8899, 2, 0, 32'h0,         5, 32'h8899AABB};
    vecs[5]  = '{1'b0, 32'h0000_0014, 2'b01, 1'b0, 32'h0,         1'b0, 32'hFFFFAABB, 2, 0, 32'h0,         5, 32'h8899AABB};
    vecs[6]  = '{1'b0, 32'h0000_0014, 2'b00, 1'b0, 32'h0,         1'b0, 32'hFFFFFFBB, 2, 0, 32'h0,         5, 32'h8899AABB};
    vecs[7]  = '{1'b1, 32'h0000_0015, 2'b00, 1'b0, 32'h0000005A,  1'b0, 32'h0,        3, 1, 32'h88995ABB,  5, 32'h88995ABB};
    vecs[8]  = '{1'b1, 32'h0000_0013, 2'b10, 1'b0, 32'h12345678,  1'b1, 32'h0,        1, 0, 32'h0,         4, 32'h11223344};
    vecs[9]  = '{1'b1, 32'h0000_0016, 2'b01, 1'b0, 32'hFFFFBEEF,  1'b0, 32'h0,        3, 1, 32'hBEEF5ABB,  5, 32'hBEEF5ABB};
    vecs[10] = '{1'b1, 32'h0000_0018, 2'b10, 1'b0, 32'hCAFEF00D,  1'b0, 32'h0,        2, 1, 32'hCAFEF00D,  6, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 32'h0000_0018, 2'b10, 1'b1, 32'h0,         1'b0, 32'hCAFEF00D, 2, 0, 32'h0,         6, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 32'h0000_0014, 2'b11, 1'b0, 32'h0,         1'b1, 32'h0,        1, 0, 32'h0,         5, 32'hBEEF5ABB};
    vecs[13] = '{1'b0, 32'h0000_0015, 2'b01, 1'b0, 32'h0,         1'b1, 32'h0,        1, 0, 32'h0,         5, 32'hBEEF5ABB};
    vecs[14] = '{1'b0, 32'h0000_1014, 2'b10, 1'b0, 32'h0,         1'b0, 32'hBEEF5ABB, 2, 0, 32'h0,         5, 32'hBEEF5ABB};
    vecs[15] = '{1'b1, 32'h0000_0018, 2'b00, 1'b1, 32'hFFFFFF77,  1'b0, 32'h0,        3, 1, 32'hCAFEF077,  6, 32'hCAFEF077};
    vecs[16] = '{1'b0, 32'h0000_0019, 2'b00, 1'b0, 32'h0,         1'b0, 32'hFFFFFFF0, 2, 0, 32'h0,         6, 32'hCAFEF077};

    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_addr_i     = 32'h0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = 32'h0;

    repeat (3) @(negedge clk);
    init_done = 1'b1;
    check("rst_ready", {31'b0, bus.req_ready_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    check("rst_mem_wr", {31'b0, bus.mem_wr_o}, 32'd0);
    check("rst_waddr", {22'b0, bus.mem_waddr_o}, 32'd0);
    check("rst_wdata", bus.mem_wdata_o, 32'd0);
    check("rst_rdata", bus.rsp_rdata_o, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, bus.req_ready_o}, 32'd1);

    for (int i = 0; i < 17; i++)
      apply(vecs[i], i);

    // Reset during the write phase of a half store must abort without a write
    @(negedge clk);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = 1'b1;
    bus.req_addr_i     = 32'h0000_001A;
    bus.req_size_i     = 2'b01;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (!seen) begin
        @(negedge clk);
        if (bus.mem_wr_o) seen = 1'b1;
      end
    end
    check("abort_reached_wr", {31'b0, seen}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_mem_wr_drop", {31'b0, bus.mem_wr_o}, 32'd0);
    check("abort_ready_in_rst", {31'b0, bus.req_ready_o}, 32'd0);
    rsp = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) rsp++;
    end
    rst_n = 1'b1;
    #1;
    check("abort_ready_after", {31'b0, bus.req_ready_o}, 32'd1);
    @(negedge clk);
    if (bus.rsp_valid_o) rsp++;
    check("abort_no_rsp", rsp, 0);
    check("abort_word_kept", mem[6], 32'hCAFEF077);

    // Back-to-back loads with valid held high
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = 1'b0;
    bus.req_addr_i     = 32'h0000_0014;
    bus.req_size_i     = 2'b10;
    bus.req_unsigned_i = 1'b0;
    acc = 0;
    rsp = 0;
    bad = 0;
    w0  = wr_count;
    for (int k = 0; k < 9; k++) begin
      if (bus.req_ready_o && acc < 10) begin
        acc_at[acc] = k;
        acc++;
      end
      if (bus.rsp_valid_o) begin
        rsp++;
        if (bus.rsp_rdata_o !== 32'hBEEF5ABB) bad++;
      end
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    check("b2b_accepts", acc, 3);
    check("b2b_responses", rsp, 3);
    check("b2b_rdata_errors", bad, 0);
    check("b2b_no_writes", wr_count - w0, 0);
    if (acc >= 3) begin
      check("b2b_gap0", acc_at[1] - acc_at[0], 3);
      check("b2b_gap1", acc_at[2] - acc_at[1], 3);
    end
    repeat (4) @(negedge clk);
    check("wdata_zero_outside_wr", idle_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
